azimuth_pattern_generator: RTL

- Multi-channel successor to the single-bit azimuth signal generator.
- Steps an azimuth index on ACP (azimuth change pulse) and zeroes it on ARP (azimuth reference pulse). Both inputs are asynchronous radar-interface signals and are synchronised internally.
- Drives CHANNELS output bits from a double-buffered pattern RAM. Software streams the next revolution's pattern into a shadow bank; the bank swaps only on ARP, so patterns change glitch-free at north.

---
 rtl/azimuth_pkg.sv | 17 +
 rtl/azimuth_pattern_generator_if.sv | 30 +++
 rtl/pulse_sync_edge.sv | 29 ++
 rtl/azimuth_pattern_generator.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/azimuth_pkg.sv
// Shared types, constants and helpers for the azimuth pattern generator.
package azimuth_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_ARP = 2'd0,
    RUN      = 2'd1,
    HOLD     = 2'd2
  } az_state_e;

  // Bits needed to hold an azimuth index in the inclusive range 0..size.
  function automatic int AZ_BITS(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/azimuth_pattern_generator_if.sv
// Radar-interface, pattern-load and status signals of the azimuth pattern generator.
interface azimuth_pattern_generator_if import azimuth_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int AZW      = AZ_BITS(4096)
);
  logic                en;
  logic                acp;
  logic                arp;
  logic [CHANNELS-1:0] load_data;
  logic                load_valid;
  logic                load_last;
  logic                load_ready;
  logic [CHANNELS-1:0] gen_signal;
  logic [AZW-1:0]      az_idx;
  logic                active_bank;
  logic                swap_pending;
  logic                overrun;

  // Host / radar side.
  modport master (
    output en, acp, arp, load_data, load_valid, load_last,
    input  load_ready, gen_signal, az_idx, active_bank, swap_pending, overrun
  );

  // Generator side.
  modport slave (
    input  en, acp, arp, load_data, load_valid, load_last,
    output load_ready, gen_signal, az_idx, active_bank, swap_pending, overrun
  );
endinterface

// File: rtl/pulse_sync_edge.sv
// Multi-stage synchroniser followed by a registered rising-edge detector.
// The one-cycle pulse appears STAGES+1 clocks after the input rises.
module pulse_sync_edge import azimuth_pkg::*; #(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);
  logic [STAGES-1:0] sync_q;
  logic              level_q;
  logic              pulse_q;

  // Shift the asynchronous level through the chain and flag its rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], async_i};
      level_q <= sync_q[STAGES-1];
      pulse_q <= sync_q[STAGES-1] & ~level_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/azimuth_pattern_generator.sv
// Multi-channel azimuth pattern generator: ACP steps an index, ARP homes it,
// and a double-buffered pattern RAM drives the channel outputs. The shadow
// bank is streamed in by software and only becomes active at north (ARP).
module azimuth_pattern_generator import azimuth_pkg::*; #(
  parameter int SIZE        = 4096,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                        sys_clk_i,
  input  logic                        sys_rst_i,
  azimuth_pattern_generator_if.slave  bus_if
);
  localparam int AZW   = AZ_BITS(SIZE);
  localparam int IDXW  = $clog2(SIZE);
  // {bank, idx} addressing; equals 2*SIZE entries when SIZE is a power of two.
  localparam int DEPTH = 2 * (2 ** IDXW);
  localparam logic [AZW-1:0] LAST_IDX = AZW'(SIZE - 1);
  localparam logic [AZW-1:0] SIZE_IDX = AZW'(SIZE);
  localparam logic [AZW-1:0] ONE_IDX  = AZW'(1);

  logic                acp_ev_s;
  logic                arp_ev_s;
  logic [AZW-1:0]      home_idx_s;

  az_state_e           state_q;
  logic [AZW-1:0]      idx_q;
  logic                overrun_q;

  logic                bank_q;
  logic                pending_q;
  logic                load_ready_q;
  logic [AZW-1:0]      wr_ptr_q;
  logic                xfer_s;
  logic                complete_s;
  logic                swap_s;

  logic [CHANNELS-1:0] ram_q [DEPTH];
  logic [IDXW:0]       wr_addr_s;
  logic [IDXW:0]       rd_addr_s;
  logic [CHANNELS-1:0] rd_data_q;
  logic                run_d1_q;
  logic [CHANNELS-1:0] gen_q;

  pulse_sync_edge #(.STAGES(SYNC_STAGES)) u_acp_sync (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .async_i (bus_if.acp),
    .pulse_o (acp_ev_s)
  );

  pulse_sync_edge #(.STAGES(SYNC_STAGES)) u_arp_sync (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .async_i (bus_if.arp),
    .pulse_o (arp_ev_s)
  );

  // A north pulse that coincides with a step lands on position 1, not 0.
  assign home_idx_s = acp_ev_s ? ONE_IDX : '0;

  // Index state machine: ARP re-homes, ACP steps, running off the end parks in HOLD.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q   <= WAIT_ARP;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_ARP: begin
          if (arp_ev_s) begin
            state_q <= RUN;
            idx_q   <= home_idx_s;
          end else begin
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (arp_ev_s) begin
            idx_q <= home_idx_s;
          end else if (acp_ev_s) begin
            if (idx_q == LAST_IDX) begin
              idx_q     <= SIZE_IDX;
              overrun_q <= 1'b1;
              state_q   <= HOLD;
            end else begin
              idx_q <= idx_q + ONE_IDX;
            end
          end
        end
        HOLD: begin
          if (arp_ev_s) begin
            state_q <= RUN;
            idx_q   <= home_idx_s;
          end
        end
        default: begin
          state_q <= WAIT_ARP;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign xfer_s     = bus_if.load_valid & load_ready_q;
  assign complete_s = xfer_s & (bus_if.load_last | (wr_ptr_q == LAST_IDX));
  // Only an already-complete shadow swaps; a load finishing on the ARP cycle waits.
  assign swap_s     = arp_ev_s & pending_q;

  // Shadow-bank loader and bank swap at north.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      bank_q       <= 1'b0;
      pending_q    <= 1'b0;
      load_ready_q <= 1'b0;
      wr_ptr_q     <= '0;
    end else if (swap_s) begin
      bank_q       <= ~bank_q;
      pending_q    <= 1'b0;
      load_ready_q <= 1'b1;
      wr_ptr_q     <= '0;
    end else if (complete_s) begin
      pending_q    <= 1'b1;
      load_ready_q <= 1'b0;
      wr_ptr_q     <= wr_ptr_q + ONE_IDX;
    end else begin
      load_ready_q <= ~pending_q;
      if (xfer_s) begin
        wr_ptr_q <= wr_ptr_q + ONE_IDX;
      end
    end
  end

  assign wr_addr_s = {~bank_q, wr_ptr_q[IDXW-1:0]};
  assign rd_addr_s = {bank_q, idx_q[IDXW-1:0]};

  // Pattern RAM: write port into the shadow bank, synchronous read of the active bank.
  always_ff @(posedge sys_clk_i) begin
    if (xfer_s) begin
      ram_q[wr_addr_s] <= bus_if.load_data;
    end
    rd_data_q <= ram_q[rd_addr_s];
  end

  // Delay the RUN qualifier to line up with the RAM read, then gate and register the outputs.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      run_d1_q <= 1'b0;
      gen_q    <= '0;
    end else begin
      run_d1_q <= (state_q == RUN);
      gen_q    <= (bus_if.en & run_d1_q) ? rd_data_q : '0;
    end
  end

  assign bus_if.gen_signal   = gen_q;
  assign bus_if.az_idx       = idx_q;
  assign bus_if.active_bank  = bank_q;
  assign bus_if.swap_pending = pending_q;
  assign bus_if.load_ready   = load_ready_q;
  assign bus_if.overrun      = overrun_q;
endmodule
